// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy flags, error pulses and registered read data.
// Optional almost_full/almost_empty outputs are enabled by defining FIFO_ALMOST_FLAGS_EN.
module sync_fifo_param #(
    parameter int WIDTH     = 9,
    parameter int DEPTH     = 8,
`ifdef FIFO_ALMOST_FLAGS_EN
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
`endif
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    output logic [WIDTH-1:0]  o_rd_data,
    output logic              o_rd_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_underflow
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    output logic              o_almost_full,
    output logic              o_almost_empty
`endif
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]  r_wr_ptr;
    logic [ADDR_W:0]  r_rd_ptr;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Pointers carry one extra MSB so equal indices can be told apart as full vs empty.
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                      (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
    assign o_count  = r_wr_ptr - r_rd_ptr;

    assign w_wr_acc = i_wr_en && !o_full;
    assign w_rd_acc = i_rd_en && !o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_clr && w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            o_rd_data   <= '0;
            o_rd_valid  <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_clr) begin
            // Flush keeps rd_data so the consumer never sees a spurious value change.
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            o_rd_valid  <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
                o_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            end
            o_rd_valid  <= w_rd_acc;
            o_overflow  <= i_wr_en && o_full;
            o_underflow <= i_rd_en && o_empty;
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [ADDR_W:0] AF_TH = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_TH = AEMPTY_TH[ADDR_W:0];

    assign o_almost_full  = (o_count >= AF_TH);
    assign o_almost_empty = (o_count <= AE_TH);
`endif

endmodule
